nios_custom_dma_mover: RTL and testbench
========================================

NIOS_CUSTOM_DMA_MOVER -- requirements
Module: nios_custom_dma_mover

Interface
REQ-001 SHALL have parameter AW, default 15, master word-address width (matches the 20480-word program/data RAM).
REQ-002 SHALL have parameter LW, default 16, transfer-length counter width in words.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port csr_address  input  2  CSR word select.
REQ-006 SHALL have ports csr_read / csr_write  input  1 each  CSR read/write strobes, no waitrequest.
REQ-007 SHALL have port csr_writedata  input  32  CSR write data.
REQ-008 SHALL have port csr_readdata  output  32  CSR read data, registered, read latency 1.
REQ-009 SHALL have port m_address  output  AW  master word address.
REQ-010 SHALL have ports m_read / m_write  output  1 each  master strobes.
REQ-011 SHALL have port m_byteenable  output  4  constant 4'hF.
REQ-012 SHALL have port m_writedata  output  32  master write data.
REQ-013 SHALL have port m_readdata  input  32  slave data, valid exactly 1 cycle after an accepted read (fixed read latency 1).
REQ-014 SHALL have port m_waitrequest  input  1  slave stall; a strobe is accepted in a cycle where it is high and m_waitrequest is low.
REQ-015 SHALL have port irq  output  1  level interrupt.

Function
REQ-016 CSR map SHALL be: 0 SRC[AW-1:0]; 1 DST[AW-1:0]; 2 LEN[LW-1:0]; 3 CTRL/STATUS (write: bit0 GO, bit1 IE, bit2 DONE_CLR write-1; read: bit0 BUSY, bit1 IE, bit2 DONE); unused bits read 0.
REQ-017 FSM SHALL have states IDLE, RD, CAP, WR.
REQ-018 IDLE: GO with LEN!=0 SHALL load working src/dst/count and go to RD next cycle; BUSY=1 from that cycle.
REQ-019 RD: m_read=1, m_address=src, held until accepted, then go to CAP.
REQ-020 CAP: SHALL latch m_readdata into data buffer; strobes low; go to WR.
REQ-021 WR: m_write=1, m_address=dst, m_writedata=buffer, held stable until accepted; on acceptance src+1, dst+1, count-1; count reaching 0 -> IDLE and DONE=1, else -> RD.
REQ-022 Minimum throughput SHALL be 3 cycles per word with m_waitrequest low.
REQ-023 Address increments SHALL wrap modulo 2^AW.
REQ-024 GO with LEN=0 SHALL set DONE next cycle with no bus strobes.
REQ-025 Writes to CSR 0-2 and GO while BUSY SHALL be ignored; IE and DONE_CLR remain writable while BUSY.
REQ-026 DONE set and DONE_CLR in same cycle: set SHALL win.
REQ-027 GO with DONE=1 SHALL clear DONE when the transfer starts.
REQ-028 irq SHALL equal DONE & IE, registered.
REQ-029 m_read and m_write SHALL never be high in the same cycle.

Reset
REQ-030 reset_n low at a clock edge SHALL force IDLE; SRC, DST, LEN, IE, DONE, buffer, csr_readdata, m_address, m_writedata = 0; m_read, m_write, irq = 0.
REQ-031 Reset mid-transfer SHALL abort with strobes low from the following cycle; no DONE, no irq.

Configuration
REQ-032 Macro DMA_MOVER_FILL_EN defined: CTRL bit3 FILL writable/readable; a FILL transfer SHALL skip RD/CAP and write SRC register value (zero-extended to 32 bits) to LEN words from DST, 1 cycle/word minimum.
REQ-033 Macro DMA_MOVER_FILL_EN undefined: bit3 ignored on write and reads 0; no fill logic instantiated.

Verification
REQ-034 SRC=0x10, DST=0x200, LEN=4, GO, RAM model preloaded 0xA0..0xA3 -> words 0x200..0x203 equal 0xA0..0xA3, DONE=1 after 12 cycles, irq low (IE=0).
REQ-035 IE=1, LEN=1, m_waitrequest high 3 cycles on read and 2 on write -> address/data held stable while stalled, irq rises one cycle after DONE; DONE_CLR drops irq next cycle.
REQ-036 SRC=0x7FFF, DST=0x7FFE, LEN=3 -> reads 0x7FFF,0x0000,0x0001; writes 0x7FFE,0x7FFF,0x0000.
REQ-037 GO with LEN=0 -> DONE=1 next cycle, zero m_read/m_write pulses; writing SRC=0x55 during a LEN=8 run -> SRC readback unchanged.
REQ-038 reset_n low during second word of LEN=8 -> strobes low next cycle, all CSRs read 0, BUSY=0.
REQ-039 With DMA_MOVER_FILL_EN: SRC=0x1234, DST=0x40, LEN=5, FILL=1 -> 0x40..0x44 = 0x00001234, no m_read pulses.

Source files
------------

// File: rtl/nios_custom_dma_mover.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nios_custom_dma_mover : CSR-programmed word mover. Avalon-style master   |
// | copies LEN words SRC->DST; optional fill mode via DMA_MOVER_FILL_EN.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module nios_custom_dma_mover #(
  parameter int AW = 15,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    csr_address,
  input  logic          csr_read,
  input  logic          csr_write,
  input  logic [31:0]   csr_writedata,
  output logic [31:0]   csr_readdata,
  output logic [AW-1:0] m_address,
  output logic          m_read,
  output logic          m_write,
  output logic [3:0]    m_byteenable,
  output logic [31:0]   m_writedata,
  input  logic [31:0]   m_readdata,
  input  logic          m_waitrequest,
  output logic          irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CAP  = 2'd2,
    S_WR   = 2'd3
  } state_t;

  localparam logic [AW-1:0] c_aw_one = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] c_lw_one = {{(LW-1){1'b0}}, 1'b1};
  localparam int            c_used_w = (AW > LW) ? AW : LW;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_src, r_dst, r_wsrc, r_wdst;
  logic [LW-1:0] r_len, r_cnt;
  logic          r_ie, r_done, r_irq;
  logic [31:0]   r_buf, r_rdata, w_rdata_mux;
  logic          w_busy, w_ctrl_wr, w_go, w_start, w_go_empty;
  logic          w_wr_acc, w_last, w_cnt_one;
  logic          w_fill_go, w_fill_mode, w_fill_rd;
  logic          w_unused_wdata;

  assign w_busy     = (r_state != S_IDLE);
  assign w_ctrl_wr  = csr_write && (csr_address == 2'd3);
  assign w_go       = w_ctrl_wr && csr_writedata[0] && !w_busy;
  assign w_start    = w_go && (r_len != '0);
  assign w_go_empty = w_go && (r_len == '0);
  assign w_cnt_one  = (r_cnt == c_lw_one);
  assign w_wr_acc   = m_write && !m_waitrequest;
  assign w_last     = w_wr_acc && w_cnt_one;

  assign w_unused_wdata = ^csr_writedata[31:c_used_w];

`ifdef DMA_MOVER_FILL_EN
  logic r_fill, r_fill_run;

  // FILL is sampled from the same CTRL write that carries GO.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fill     <= 1'b0;
      r_fill_run <= 1'b0;
    end else begin
      if (w_ctrl_wr && !w_busy) r_fill <= csr_writedata[3];
      if (w_start)              r_fill_run <= csr_writedata[3];
    end
  end

  assign w_fill_go   = csr_writedata[3];
  assign w_fill_mode = r_fill_run;
  assign w_fill_rd   = r_fill;
`else
  assign w_fill_go   = 1'b0;
  assign w_fill_mode = 1'b0;
  assign w_fill_rd   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    m_read      = 1'b0;
    m_write     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = w_fill_go ? S_WR : S_RD;
      end
      S_RD: begin
        m_read = 1'b1;
        if (!m_waitrequest) w_state_nxt = S_CAP;
      end
      S_CAP: begin
        w_state_nxt = S_WR;
      end
      S_WR: begin
        m_write = 1'b1;
        if (!m_waitrequest) begin
          if (w_cnt_one)        w_state_nxt = S_IDLE;
          else if (w_fill_mode) w_state_nxt = S_WR;
          else                  w_state_nxt = S_RD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdata_mux = '0;
    case (csr_address)
      2'd0:    w_rdata_mux[AW-1:0] = r_src;
      2'd1:    w_rdata_mux[AW-1:0] = r_dst;
      2'd2:    w_rdata_mux[LW-1:0] = r_len;
      default: w_rdata_mux[3:0]    = {w_fill_rd, r_done, r_ie, w_busy};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_ie    <= 1'b0;
      r_done  <= 1'b0;
      r_irq   <= 1'b0;
      r_wsrc  <= '0;
      r_wdst  <= '0;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_rdata <= '0;
    end else begin
      if (csr_write && !w_busy) begin
        case (csr_address)
          2'd0:    r_src <= csr_writedata[AW-1:0];
          2'd1:    r_dst <= csr_writedata[AW-1:0];
          2'd2:    r_len <= csr_writedata[LW-1:0];
          default: ;
        endcase
      end
      if (w_ctrl_wr) r_ie <= csr_writedata[1];

      // Later assignments take priority: a completing transfer beats DONE_CLR.
      if (w_ctrl_wr && csr_writedata[2]) r_done <= 1'b0;
      if (w_start)                       r_done <= 1'b0;
      if (w_last || w_go_empty)          r_done <= 1'b1;

      if (w_start) begin
        r_wsrc <= r_src;
        r_wdst <= r_dst;
        r_cnt  <= r_len;
        if (w_fill_go) r_buf <= {{(32-AW){1'b0}}, r_src};
      end
      if (r_state == S_CAP) r_buf <= m_readdata;
      if (w_wr_acc) begin
        r_wsrc <= r_wsrc + c_aw_one;
        r_wdst <= r_wdst + c_aw_one;
        r_cnt  <= r_cnt - c_lw_one;
      end

      r_irq <= r_done & r_ie;
      if (csr_read) r_rdata <= w_rdata_mux;
    end
  end

  assign m_address    = (r_state == S_WR) ? r_wdst : r_wsrc;
  assign m_writedata  = r_buf;
  assign m_byteenable = 4'hF;
  assign csr_readdata = r_rdata;
  assign irq          = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_nios_custom_dma_mover.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nios_custom_dma_mover : directed + randomized bench with RAM slave    |
// | and a sequential copy reference model.                                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_nios_custom_dma_mover;
  localparam int AW   = 15;
  localparam int LW   = 16;
  localparam int MASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    csr_address = '0;
  logic          csr_read = 1'b0, csr_write = 1'b0;
  logic [31:0]   csr_writedata = '0, csr_readdata;
  logic [AW-1:0] m_address;
  logic          m_read, m_write, irq;
  logic [3:0]    m_byteenable;
  logic [31:0]   m_writedata;
  logic [31:0]   m_readdata = '0;
  logic          m_waitrequest = 1'b0;

  always #5 clk = ~clk;

  nios_custom_dma_mover #(.AW(AW), .LW(LW)) dut (
    .clk(clk), .reset_n(reset_n),
    .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_byteenable(m_byteenable), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .m_waitrequest(m_waitrequest), .irq(irq)
  );

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // RAM slave with fixed read latency 1, plus a backdoor write port
  logic [31:0]   mem     [0:MASK];
  logic [31:0]   ref_mem [0:MASK];
  bit            mem_ready = 1'b0;
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [31:0]   bd_data = '0;
  int            cyc = 0;
  logic [AW-1:0] rd_log[$], wr_alog[$];
  logic [31:0]   wr_dlog[$];

  function automatic logic [31:0] init_val(input int i);
    return (i * 32'h9E3779B1) ^ 32'h00C0FFEE;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!mem_ready) begin
      for (int i = 0; i <= MASK; i++) mem[i] = init_val(i);
      mem_ready = 1'b1;
    end
    if (bd_we) mem[bd_addr] = bd_data;
    if (m_read && !m_waitrequest) begin
      m_readdata <= mem[m_address];
      rd_log.push_back(m_address);
    end
    if (m_write && !m_waitrequest) begin
      mem[m_address] = m_writedata;
      wr_alog.push_back(m_address);
      wr_dlog.push_back(m_writedata);
    end
  end

  // Waitrequest generator and bus-protocol monitor
  int            rd_stall_cfg = 0, wr_stall_cfg = 0;
  bit            stall_rand = 1'b0;
  int            st_cnt = 0, n_rd = 0, n_wr = 0, acc_wr_cyc = -1, mon_viol = 0;
  logic          prev_stall = 1'b0, prev_rd = 1'b0, ws;
  logic [AW-1:0] prev_addr = '0;
  logic [31:0]   prev_wd = '0;

  always @(negedge clk) begin
    if (reset_n && m_read && m_write) mon_viol++;
    if (reset_n && prev_stall) begin
      if ((prev_rd ? m_read : m_write) !== 1'b1 || m_address !== prev_addr ||
          (!prev_rd && m_writedata !== prev_wd)) mon_viol++;
    end
    if (m_read)  n_rd++;
    if (m_write) n_wr++;
    if (m_read && st_cnt < rd_stall_cfg)       ws = 1'b1;
    else if (m_write && st_cnt < wr_stall_cfg) ws = 1'b1;
    else                                       ws = stall_rand && ($urandom_range(0, 2) == 0);
    st_cnt = ws ? st_cnt + 1 : 0;
    m_waitrequest = ws;
    if (m_write && !ws) acc_wr_cyc = cyc;
    prev_stall = ws && (m_read || m_write);
    prev_rd    = m_read;
    prev_addr  = m_address;
    prev_wd    = m_writedata;
  end

  // Tasks are entered on a falling edge and return on the next falling edge
  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    @(negedge clk);
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    csr_address = a; csr_read = 1'b1;
    @(negedge clk);
    d = csr_readdata;
    csr_read = 1'b0;
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    bd_addr = a[AW-1:0]; bd_data = d; bd_we = 1'b1;
    ref_mem[a] = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output logic [31:0] s);
    int n;
    n = 0;
    do begin
      csr_rd(2'd3, s);
      n++;
    end while (s[0] && n < 500);
    check({tag, " busy timeout"}, {31'b0, s[0]}, 32'h0);
  endtask

  // Reference: word i copies ref[src+i] to dst+i in order, addresses modulo 2^AW
  logic [AW-1:0] exp_ra[$], exp_wa[$];
  logic [31:0]   exp_wd[$];

  task automatic model_xfer(input int src, input int dst, input int len, input bit fill);
    int ra, wa;
    logic [31:0] d;
    exp_ra.delete(); exp_wa.delete(); exp_wd.delete();
    for (int i = 0; i < len; i++) begin
      ra = (src + i) & MASK;
      wa = (dst + i) & MASK;
      d  = fill ? (src & MASK) : ref_mem[ra];
      if (!fill) exp_ra.push_back(ra[AW-1:0]);
      exp_wa.push_back(wa[AW-1:0]);
      exp_wd.push_back(d);
      ref_mem[wa] = d;
    end
  endtask

  task automatic verify(input string tag, input int r0, input int w0);
    check({tag, " read count"}, rd_log.size() - r0, exp_ra.size());
    check({tag, " write count"}, wr_alog.size() - w0, exp_wa.size());
    for (int i = 0; i < exp_ra.size(); i++)
      if (r0 + i < rd_log.size()) check({tag, " read addr"}, rd_log[r0+i], exp_ra[i]);
    for (int i = 0; i < exp_wa.size(); i++)
      if (w0 + i < wr_alog.size()) begin
        check({tag, " write addr"}, wr_alog[w0+i], exp_wa[i]);
        check({tag, " write data"}, wr_dlog[w0+i], exp_wd[i]);
      end
    for (int i = 0; i < exp_wa.size(); i++)
      check({tag, " ram word"}, mem[exp_wa[i]], ref_mem[exp_wa[i]]);
  endtask

  task automatic run_xfer(input string tag, input int src, input int dst, input int len, input bit fill);
    int r0, w0;
    logic [31:0] s;
    model_xfer(src, dst, len, fill);
    r0 = rd_log.size(); w0 = wr_alog.size();
    csr_wr(2'd0, src); csr_wr(2'd1, dst); csr_wr(2'd2, len);
    csr_wr(2'd3, fill ? 32'h9 : 32'h1);
    wait_idle(tag, s);
    check({tag, " done"}, {31'b0, s[2]}, 32'h1);
    verify(tag, r0, w0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s;
    int r0, w0, nr0, nw0, n;

    for (int i = 0; i <= MASK; i++) ref_mem[i] = init_val(i);
    repeat (3) @(negedge clk);

    // Reset state
    check("rst m_read", {31'b0, m_read}, 0);
    check("rst m_write", {31'b0, m_write}, 0);
    check("rst irq", {31'b0, irq}, 0);
    check("rst m_address", m_address, 0);
    check("rst m_writedata", m_writedata, 0);
    check("rst csr_readdata", csr_readdata, 0);
    check("byteenable", m_byteenable, 32'hF);
    reset_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      csr_rd(a[1:0], s);
      check("rst csr read", s, 0);
    end

    // Basic 4-word copy with exact completion latency
    for (int i = 0; i < 4; i++) poke(32'h10 + i, 32'hA0 + i);
    model_xfer(32'h10, 32'h200, 4, 1'b0);
    r0 = rd_log.size(); w0 = wr_alog.size(); nr0 = n_rd; nw0 = n_wr;
    csr_wr(2'd0, 32'h10); csr_wr(2'd1, 32'h200); csr_wr(2'd2, 32'd4);
    csr_wr(2'd3, 32'h1);
    repeat (11) @(negedge clk);
    csr_rd(2'd3, s);
    check("copy4 status at cycle 12", s, 32'h1);
    csr_rd(2'd3, s);
    check("copy4 status after cycle 12", s, 32'h4);
    verify("copy4", r0, w0);
    for (int i = 0; i < 4; i++) check("copy4 literal", mem[32'h200 + i], 32'hA0 + i);
    check("copy4 read strobes", n_rd - nr0, 4);
    check("copy4 write strobes", n_wr - nw0, 4);
    check("copy4 irq", {31'b0, irq}, 0);

    // Stalled single word with interrupt
    rd_stall_cfg = 3; wr_stall_cfg = 2;
    model_xfer(32'h300, 32'h400, 1, 1'b0);
    r0 = rd_log.size(); w0 = wr_alog.size(); nr0 = n_rd; nw0 = n_wr;
    csr_wr(2'd0, 32'h300); csr_wr(2'd1, 32'h400); csr_wr(2'd2, 32'd1);
    csr_wr(2'd3, 32'h3);
    n = 0;
    while (irq !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("stall irq rise cycle", cyc, acc_wr_cyc + 2);
    check("stall read strobes", n_rd - nr0, 4);
    check("stall write strobes", n_wr - nw0, 3);
    verify("stall", r0, w0);
    rd_stall_cfg = 0; wr_stall_cfg = 0;
    csr_wr(2'd3, 32'h6);
    check("irq held one cycle after clr", {31'b0, irq}, 1);
    @(negedge clk);
    check("irq dropped after clr", {31'b0, irq}, 0);
    csr_rd(2'd3, s);
    check("status after clr", s, 32'h2);
    csr_wr(2'd3, 32'h0);
    check("stall protocol", mon_viol, 0);

    // Address wrap with random stalls
    stall_rand = 1'b1;
    run_xfer("wrap", 32'h7FFF, 32'h7FFE, 3, 1'b0);
    if (rd_log.size() >= 3) check("wrap 2nd read", rd_log[rd_log.size()-2], 32'h0000);
    if (wr_alog.size() >= 3) check("wrap last write", wr_alog[wr_alog.size()-1], 32'h0000);
    stall_rand = 1'b0;

    // LEN=0 and busy write protection
    csr_wr(2'd3, 32'h4);
    csr_rd(2'd3, s);
    check("done cleared", s, 32'h0);
    nr0 = n_rd; nw0 = n_wr;
    csr_wr(2'd2, 32'd0);
    csr_wr(2'd3, 32'h1);
    csr_rd(2'd3, s);
    check("len0 done next cycle", s, 32'h4);
    repeat (4) @(negedge clk);
    check("len0 no reads", n_rd - nr0, 0);
    check("len0 no writes", n_wr - nw0, 0);

    model_xfer(32'h100, 32'h500, 8, 1'b0);
    r0 = rd_log.size(); w0 = wr_alog.size();
    csr_wr(2'd0, 32'h100); csr_wr(2'd1, 32'h500); csr_wr(2'd2, 32'd8);
    csr_wr(2'd3, 32'h1);
    csr_wr(2'd0, 32'h55);
    csr_wr(2'd2, 32'd3);
    csr_wr(2'd3, 32'h1);
    csr_rd(2'd3, s);
    check("len8 busy, done cleared on start", s, 32'h1);
    csr_rd(2'd0, s);
    check("src write ignored while busy", s, 32'h100);
    csr_rd(2'd2, s);
    check("len write ignored while busy", s, 32'd8);
    wait_idle("len8", s);
    verify("len8", r0, w0);

    // Randomized copies
    stall_rand = 1'b1;
    for (int k = 0; k < 6; k++)
      run_xfer("random", $urandom & MASK, $urandom & MASK, $urandom_range(1, 6), 1'b0);
    stall_rand = 1'b0;

    // FILL control bit
    csr_wr(2'd3, 32'h8);
    csr_rd(2'd3, s);
`ifdef DMA_MOVER_FILL_EN
    check("fill bit readback", {31'b0, s[3]}, 1);
    nr0 = n_rd;
    run_xfer("fill", 32'h1234, 32'h40, 5, 1'b1);
    for (int i = 0; i < 5; i++) check("fill literal", mem[32'h40 + i], 32'h00001234);
    check("fill no reads", n_rd - nr0, 0);
`else
    check("fill bit reads zero", {31'b0, s[3]}, 0);
`endif

    // Reset during the second word
    model_xfer(32'h600, 32'h700, 1, 1'b0);
    w0 = wr_alog.size();
    csr_wr(2'd0, 32'h600); csr_wr(2'd1, 32'h700); csr_wr(2'd2, 32'd8);
    csr_wr(2'd3, 32'h3);
    for (n = 0; n < 100 && wr_alog.size() == w0; n++) @(negedge clk);
    check("abort first word written", wr_alog.size() - w0, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort m_read", {31'b0, m_read}, 0);
    check("abort m_write", {31'b0, m_write}, 0);
    check("abort irq", {31'b0, irq}, 0);
    check("abort m_address", m_address, 0);
    check("abort m_writedata", m_writedata, 0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      csr_rd(a[1:0], s);
      check("abort csr read", s, 0);
    end
    repeat (3) @(negedge clk);
    check("abort no more writes", wr_alog.size() - w0, 1);
    check("abort irq stays low", {31'b0, irq}, 0);
    check("abort word0", mem[32'h700], ref_mem[32'h700]);
    check("abort word1 untouched", mem[32'h701], ref_mem[32'h701]);

    check("bus protocol", mon_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
